score_keeper: RTL and testbench

Game-progress tracker that produces the one-cycle `newHighScore` and `died` event pulses consumed by the face-display logic. It counts points in BCD, tracks remaining lives with a post-hit invulnerability window, and keeps a high score across games. At game over it emits exactly one outcome pulse, so the face logic never sees both events in the same game.

---
 rtl/score_keeper.sv | 93 +++++++++
 tb/tb_score_keeper.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/score_keeper.sv
// score_keeper: BCD score, lives and high-score tracker emitting one outcome pulse per game
module score_keeper #(
  parameter int LIVES           = 3,
  parameter int COOLDOWN_CYCLES = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       gameStart,
  input  logic       point,
  input  logic       collision,
  output logic [7:0] score,
  output logic [7:0] highScore,
  output logic [1:0] lives,
  output logic       playing,
  output logic       newHighScore,
  output logic       died
);
  typedef enum logic [1:0] {IDLE, PLAY, COOLDOWN, GAMEOVER} state_t;
  state_t      r_state, w_state;
  logic [7:0]  r_score, r_high, w_score, w_high, w_inc;
  logic [1:0]  r_lives, w_lives;
  logic [25:0] r_cnt, w_cnt;
  logic        r_playing, r_new, r_died, w_new, w_died;
  // saturating two-digit BCD increment of the current score
  assign w_inc = (r_score == 8'h99) ? 8'h99 :
                 (r_score[3:0] == 4'd9) ? {r_score[7:4] + 4'd1, 4'd0} :
                 r_score + 8'd1;
  // next-state, scoring, lives and outcome-pulse decisions
  always_comb begin
    w_state = r_state;
    w_score = r_score;
    w_high  = r_high;
    w_lives = r_lives;
    w_cnt   = r_cnt;
    w_new   = 1'b0;
    w_died  = 1'b0;
    case (r_state)
      IDLE, GAMEOVER: if (gameStart) begin
        w_score = 8'h00;
        w_lives = 2'(LIVES);
        w_state = PLAY;
      end
      PLAY: begin
        w_score = point ? w_inc : r_score;
        if (collision && r_lives > 2'd1) begin
          w_lives = r_lives - 2'd1;
          w_cnt   = 26'(COOLDOWN_CYCLES - 1);
          w_state = COOLDOWN;
        end else if (collision) begin
          w_lives = 2'd0;
          w_state = GAMEOVER;
          w_new   = w_score > r_high;
          w_died  = !(w_score > r_high);
          w_high  = (w_score > r_high) ? w_score : r_high;
        end
      end
      COOLDOWN: begin
        w_score = point ? w_inc : r_score;
        w_cnt   = (r_cnt == 26'd0) ? r_cnt : r_cnt - 26'd1;
        w_state = (r_cnt == 26'd0) ? PLAY : COOLDOWN;
      end
      default: w_state = IDLE;
    endcase
  end
  // state and output registers, cleared asynchronously by the active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_score   <= 8'h00;
      r_high    <= 8'h00;
      r_lives   <= 2'd0;
      r_cnt     <= 26'd0;
      r_playing <= 1'b0;
      r_new     <= 1'b0;
      r_died    <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_score   <= w_score;
      r_high    <= w_high;
      r_lives   <= w_lives;
      r_cnt     <= w_cnt;
      r_playing <= (w_state == PLAY) || (w_state == COOLDOWN);
      r_new     <= w_new;
      r_died    <= w_died;
    end
  end
  assign score        = r_score;
  assign highScore    = r_high;
  assign lives        = r_lives;
  assign playing      = r_playing;
  assign newHighScore = r_new;
  assign died         = r_died;
endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized and directed stimulus against an integer game model with a pulse scoreboard
module tb_score_keeper;
  localparam int L = 3;
  localparam int C = 4;
  logic       clk = 1'b0, rst = 1'b0, gameStart = 1'b0, point = 1'b0, collision = 1'b0;
  logic [7:0] score, highScore;
  logic [1:0] lives;
  logic       playing, newHighScore, died;
  int checks = 0, errors = 0, cyc = 0;
  int m_score, m_high, m_lives, m_hit;
  bit m_play;
  typedef struct {bit nh; logic [7:0] hs; int cyc;} exp_t;
  exp_t q[$];

  score_keeper #(.LIVES(L), .COOLDOWN_CYCLES(C)) dut (
    .clk(clk), .rst(rst), .gameStart(gameStart), .point(point), .collision(collision),
    .score(score), .highScore(highScore), .lives(lives), .playing(playing),
    .newHighScore(newHighScore), .died(died)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] bcd(input int s);
    return 8'((s / 10) * 16 + s % 10);
  endfunction

  task automatic chk(input string n, input logic [7:0] a, input logic [7:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc, a, e);
    end
  endtask

  task automatic model_reset();
    m_play = 0; m_score = 0; m_high = 0; m_lives = 0; m_hit = -1000;
  endtask

  task automatic step(input bit gs, input bit pt, input bit co);
    int e;
    e = cyc + 1;
    gameStart = gs; point = pt; collision = co;
    if (!m_play) begin
      if (gs) begin
        m_score = 0; m_lives = L; m_play = 1; m_hit = -1000;
      end
    end else begin
      if (pt) m_score = (m_score < 99) ? m_score + 1 : 99;
      if (co && e > m_hit + C) begin
        if (m_lives > 1) begin
          m_lives--; m_hit = e;
        end else begin
          m_lives = 0; m_play = 0;
          q.push_back('{nh: m_score > m_high, hs: bcd(m_score > m_high ? m_score : m_high), cyc: e});
          if (m_score > m_high) m_high = m_score;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    gameStart = 0; point = 0; collision = 0;
    chk("score", score, bcd(m_score));
    chk("highScore", highScore, bcd(m_high));
    chk("lives", {6'd0, lives}, 8'(m_lives));
    chk("playing", {7'd0, playing}, {7'd0, m_play});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic points(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0);
  endtask

  task automatic die_spaced();
    for (int i = 0; i < L; i++) begin
      step(0, 0, 1);
      idle(C + 1);
    end
  endtask

  // scoreboard monitor: every outcome pulse must match the oldest expected game result
  always @(negedge clk) begin
    exp_t x;
    if (newHighScore && died) begin
      checks++; errors++;
      $display("FAIL both_pulses at cycle %0d: newHighScore=1 died=1 expected at most one", cyc);
    end else if (newHighScore || died) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse at cycle %0d: newHighScore=%0b died=%0b expected none", cyc, newHighScore, died);
      end else begin
        x = q.pop_front();
        if (newHighScore !== x.nh || highScore !== x.hs || cyc != x.cyc) begin
          errors++;
          $display("FAIL outcome at cycle %0d: nh=%0b hs=%h cyc=%0d expected nh=%0b hs=%h cyc=%0d",
                   cyc, newHighScore, highScore, cyc, x.nh, x.hs, x.cyc);
        end
      end
    end else if (q.size() > 0 && q[0].cyc <= cyc) begin
      checks++; errors++;
      $display("FAIL missed_pulse at cycle %0d: no pulse expected nh=%0b at cycle %0d", cyc, q[0].nh, q[0].cyc);
      void'(q.pop_front());
    end
  end

  initial begin
    model_reset();
    #2;
    chk("rst_score", score, 8'h00);
    chk("rst_high", highScore, 8'h00);
    chk("rst_lives", {6'd0, lives}, 8'h00);
    chk("rst_pulses", {5'd0, playing, newHighScore, died}, 8'h00);
    @(negedge clk);
    rst = 1;
    idle(2);
    step(1, 0, 0); points(12);
    step(1, 0, 0);
    die_spaced();
    step(1, 0, 0); points(12); die_spaced();
    step(1, 0, 0); points(11);
    step(0, 0, 1); idle(C + 1);
    step(0, 0, 1); idle(C + 1);
    step(0, 1, 0);
    step(0, 1, 1); idle(2);
    step(1, 0, 0); points(5); die_spaced();
    step(1, 0, 0); points(14); die_spaced();
    step(1, 1, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 1);
    idle(3);
    step(1, 0, 0); points(105); step(0, 1, 1); idle(2);
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 19) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0);
    while (m_play) step(0, 0, 1);
    idle(2);
    step(1, 0, 0); points(20);
    step(0, 0, 1); step(0, 0, 0);
    #2 rst = 0;
    #1;
    chk("mid_rst_score", score, 8'h00);
    chk("mid_rst_high", highScore, 8'h00);
    chk("mid_rst_lives", {6'd0, lives}, 8'h00);
    chk("mid_rst_pulses", {5'd0, playing, newHighScore, died}, 8'h00);
    model_reset();
    q.delete();
    @(negedge clk);
    rst = 1;
    idle(2);
    step(0, 1, 1);
    step(1, 0, 0); points(3); die_spaced();
    idle(2);
    chk("queue_drained", 8'(q.size()), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
